// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks outstanding long-latency writes and raises
// a combinational stall for load-use, RAW-on-pending, WAW and tracker-full cases.
module hazard_scoreboard #(
  parameter int MAX_PEND = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  Rs1_i,
  input  logic [4:0]  Rs2_i,
  input  logic        Rs1Use_i,
  input  logic        Rs2Use_i,
  input  logic [4:0]  EXRd_i,
  input  logic        EXMemRead_i,
  input  logic        Issue_i,
  input  logic [4:0]  IssueRd_i,
  input  logic        Done_i,
  input  logic [4:0]  DoneRd_i,
  output logic        Stall_o,
  output logic [3:0]  PendCnt_o,
  output logic        Full_o,
  output logic        Err_o,
  output logic [15:0] StallCnt_o
);

  localparam logic [3:0] MAX_PEND_C = 4'(MAX_PEND);

  logic [31:0] pend_q, pend_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic full_s, done_valid_s, accept_s;
  logic load_use_s, raw1_s, raw2_s, waw_s, full_stall_s, stall_s;

  function automatic logic is_pend(input logic [31:0] vec, input logic [4:0] rd);
    is_pend = (rd != 5'd0) && vec[rd];
  endfunction

  assign full_s       = (cnt_q == MAX_PEND_C);
  assign done_valid_s = Done_i && is_pend(pend_q, DoneRd_i);

  assign load_use_s = EXMemRead_i && (EXRd_i != 5'd0) &&
                      ((Rs1Use_i && (Rs1_i == EXRd_i)) || (Rs2Use_i && (Rs2_i == EXRd_i)));

  // A source written back this very cycle is forwarded from WB, so it does not stall.
  assign raw1_s = Rs1Use_i && is_pend(pend_q, Rs1_i) && !(Done_i && (DoneRd_i == Rs1_i));
  assign raw2_s = Rs2Use_i && is_pend(pend_q, Rs2_i) && !(Done_i && (DoneRd_i == Rs2_i));
  assign waw_s  = Issue_i && is_pend(pend_q, IssueRd_i) && !(Done_i && (DoneRd_i == IssueRd_i));

  // Only a done that really frees a slot lets a full tracker take a new issue.
  assign full_stall_s = Issue_i && full_s && !done_valid_s;

  assign stall_s  = load_use_s || raw1_s || raw2_s || waw_s || full_stall_s;
  assign accept_s = Issue_i && !stall_s && (IssueRd_i != 5'd0);

  // Next-state computation for pending vector, counters and error flag.
  always_comb begin
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q;

    // Clear before set so a same-register done plus issue leaves the bit set.
    if (done_valid_s) begin
      pend_d[DoneRd_i] = 1'b0;
    end else begin
      pend_d[DoneRd_i] = pend_q[DoneRd_i];
    end
    if (accept_s) begin
      pend_d[IssueRd_i] = 1'b1;
    end else begin
      pend_d[IssueRd_i] = pend_d[IssueRd_i];
    end
    pend_d[0] = 1'b0;

    case ({accept_s, done_valid_s})
      2'b10:   cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = cnt_q - 4'd1;
      default: cnt_d = cnt_q;
    endcase

    if (Done_i && !done_valid_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    if (stall_s && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pend_q      <= 32'd0;
      cnt_q       <= 4'd0;
      err_q       <= 1'b0;
      stall_cnt_q <= 16'd0;
    end else begin
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign Stall_o    = stall_s;
  assign PendCnt_o  = cnt_q;
  assign Full_o     = full_s;
  assign Err_o      = err_q;
  assign StallCnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Table-driven bench for hazard_scoreboard with a queue of expected post-edge state.
module tb_hazard_scoreboard;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [4:0]  Rs1_i, Rs2_i, EXRd_i, IssueRd_i, DoneRd_i;
  logic        Rs1Use_i, Rs2Use_i, EXMemRead_i, Issue_i, Done_i;
  logic        Stall_o, Full_o, Err_o;
  logic [3:0]  PendCnt_o;
  logic [15:0] StallCnt_o;

  hazard_scoreboard #(.MAX_PEND(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .Rs1_i(Rs1_i), .Rs2_i(Rs2_i), .Rs1Use_i(Rs1Use_i), .Rs2Use_i(Rs2Use_i),
    .EXRd_i(EXRd_i), .EXMemRead_i(EXMemRead_i),
    .Issue_i(Issue_i), .IssueRd_i(IssueRd_i),
    .Done_i(Done_i), .DoneRd_i(DoneRd_i),
    .Stall_o(Stall_o), .PendCnt_o(PendCnt_o), .Full_o(Full_o),
    .Err_o(Err_o), .StallCnt_o(StallCnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int u1, rs1, u2, rs2, exmr, exrd, iss, issrd, done, donerd;
    int stall, cnt, full, err;
  } vec_t;

  typedef struct {
    int cnt, full, err, scnt;
  } post_t;

  vec_t  tbl[25];
  post_t sb_q[$];
  int    checks = 0;
  int    errors = 0;
  int    exp_scnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    Rs1Use_i = 1'(v.u1);  Rs1_i = 5'(v.rs1);
    Rs2Use_i = 1'(v.u2);  Rs2_i = 5'(v.rs2);
    EXMemRead_i = 1'(v.exmr); EXRd_i = 5'(v.exrd);
    Issue_i = 1'(v.iss);  IssueRd_i = 5'(v.issrd);
    Done_i = 1'(v.done);  DoneRd_i = 5'(v.donerd);
  endtask

  function automatic vec_t idle();
    vec_t v = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0};
    return v;
  endfunction

  // Called just after a negedge: drive, check the combinational stall, clock, check state.
  task automatic run_row(input vec_t v, input string tag);
    post_t p, got;
    drive(v);
    #1;
    chk({tag, ".stall"}, int'(Stall_o), v.stall);
    if (v.stall != 0 && exp_scnt < 65535) exp_scnt++;
    p = '{v.cnt, v.full, v.err, exp_scnt};
    sb_q.push_back(p);
    @(posedge clk_i);
    #1;
    got = sb_q.pop_front();
    chk({tag, ".cnt"},  int'(PendCnt_o),  got.cnt);
    chk({tag, ".full"}, int'(Full_o),     got.full);
    chk({tag, ".err"},  int'(Err_o),      got.err);
    chk({tag, ".scnt"}, int'(StallCnt_o), got.scnt);
    @(negedge clk_i);
  endtask

  initial begin
    vec_t v;
    // Fields: u1 rs1 u2 rs2 exmr exrd iss issrd done donerd | stall cnt full err
    tbl[0]  = '{0,0, 1,5, 1,5, 0,0, 0,0,   1,0,0,0}; // load-use via rs2
    tbl[1]  = '{0,0, 1,5, 1,0, 0,0, 0,0,   0,0,0,0}; // EXRd = x0
    tbl[2]  = '{1,6, 0,0, 1,6, 0,0, 0,0,   1,0,0,0}; // load-use via rs1
    tbl[3]  = '{0,6, 0,0, 1,6, 0,0, 0,0,   0,0,0,0}; // source not used
    tbl[4]  = '{0,0, 0,0, 0,0, 1,7, 0,0,   0,1,0,0}; // issue x7
    tbl[5]  = '{1,7, 0,0, 0,0, 0,0, 0,0,   1,1,0,0}; // RAW on x7
    tbl[6]  = '{1,7, 0,0, 0,0, 0,0, 1,7,   0,0,0,0}; // done x7 forwards
    tbl[7]  = '{1,7, 0,0, 0,0, 0,0, 0,0,   0,0,0,0}; // x7 free
    tbl[8]  = '{0,0, 0,0, 0,0, 1,1, 0,0,   0,1,0,0};
    tbl[9]  = '{0,0, 0,0, 0,0, 1,2, 0,0,   0,2,0,0};
    tbl[10] = '{0,0, 0,0, 0,0, 1,3, 0,0,   0,3,0,0};
    tbl[11] = '{0,0, 0,0, 0,0, 1,4, 0,0,   0,4,1,0}; // full
    tbl[12] = '{0,0, 0,0, 0,0, 1,9, 0,0,   1,4,1,0}; // issue blocked by full
    tbl[13] = '{0,0, 0,0, 0,0, 1,9, 1,2,   0,4,1,0}; // issue with done frees slot
    tbl[14] = '{0,0, 0,0, 0,0, 1,3, 0,0,   1,4,1,0}; // WAW on x3
    tbl[15] = '{0,0, 0,0, 0,0, 1,3, 1,3,   0,4,1,0}; // same-reg issue+done
    tbl[16] = '{0,0, 0,0, 0,0, 1,0, 0,0,   1,4,1,0}; // x0 issue still blocked when full
    tbl[17] = '{0,0, 0,0, 0,0, 0,0, 1,1,   0,3,0,0};
    tbl[18] = '{0,0, 0,0, 0,0, 0,0, 1,4,   0,2,0,0}; // x3, x9 remain
    tbl[19] = '{0,0, 0,0, 0,0, 1,0, 0,0,   0,2,0,0}; // untracked x0 issue
    tbl[20] = '{0,0, 1,9, 0,0, 0,0, 0,0,   1,2,0,0}; // RAW via rs2
    tbl[21] = '{1,0, 0,0, 0,0, 0,0, 0,0,   0,2,0,0}; // x0 never pending
    tbl[22] = '{0,0, 0,0, 0,0, 0,0, 1,12,  0,2,0,1}; // done on idle reg
    tbl[23] = '{0,0, 0,0, 0,0, 0,0, 0,0,   0,2,0,1}; // error is sticky
    tbl[24] = '{0,0, 0,0, 0,0, 0,0, 1,0,   0,2,0,1}; // done on x0

    rst_i = 1'b0;
    drive(idle());
    repeat (2) @(negedge clk_i);
    chk("reset.cnt", int'(PendCnt_o), 0);
    chk("reset.full", int'(Full_o), 0);
    chk("reset.err", int'(Err_o), 0);
    chk("reset.scnt", int'(StallCnt_o), 0);
    chk("reset.stall", int'(Stall_o), 0);
    rst_i = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 25; i++) run_row(tbl[i], $sformatf("row%0d", i));

    // Saturate the stall counter with a held load-use hazard.
    v = tbl[0];
    drive(v);
    repeat (65540) @(posedge clk_i);
    #1;
    chk("sat.scnt", int'(StallCnt_o), 65535);
    @(posedge clk_i);
    #1;
    chk("sat.hold", int'(StallCnt_o), 65535);
    chk("sat.cnt", int'(PendCnt_o), 2);
    drive(idle());
    @(negedge clk_i);

    // Asynchronous reset mid-cycle with two writes outstanding.
    #2;
    rst_i = 1'b0;
    #1;
    chk("mid.cnt", int'(PendCnt_o), 0);
    chk("mid.full", int'(Full_o), 0);
    chk("mid.err", int'(Err_o), 0);
    chk("mid.scnt", int'(StallCnt_o), 0);
    chk("mid.stall", int'(Stall_o), 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);

    exp_scnt = 0;
    run_row('{1,3, 1,9, 0,0, 0,0, 0,0,  0,0,0,0}, "post.raw");
    run_row('{0,0, 0,0, 0,0, 1,5, 0,0,  0,1,0,0}, "post.issue");
    run_row('{0,0, 0,0, 0,0, 0,0, 1,5,  0,0,0,0}, "post.done");

    chk("sb.empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
